// File: rtl/node_elastic_fifo.sv
// Elastic valid/ready FIFO node. Both handshake outputs come from flops, which breaks long ready chains.
// Optional occupancy statistics (stall_cnt, hwm) are enabled by defining NODE_ELASTIC_FIFO_STATS_EN.
module node_elastic_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             up_valid_in,
  output logic             up_ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             dn_valid_out,
  input  logic             dn_ready_in,
`ifdef NODE_ELASTIC_FIFO_STATS_EN
  output logic [15:0]      stall_cnt,
  output logic [CW-1:0]    hwm,
`endif
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_up_ready;
  logic             r_dn_valid;
  logic             w_up_fire;
  logic             w_dn_fire;
  logic [CW-1:0]    w_count_next;

  assign w_up_fire    = up_valid_in & r_up_ready;
  assign w_dn_fire    = r_dn_valid & dn_ready_in;
  assign up_ready_out = r_up_ready;
  assign dn_valid_out = r_dn_valid;
  assign count        = r_count;
  assign data_out     = r_mem[r_rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_up_fire && !w_dn_fire) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_up_fire && w_dn_fire) begin
      w_count_next = r_count - CW'(1);
    end else begin
      w_count_next = r_count;
    end
  end

  // Storage: cleared by reset only; flush leaves the contents stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_up_fire && !flush) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and the registered status flags derived from the next count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_up_ready <= 1'b1;
      r_dn_valid <= 1'b0;
    end else begin
      if (w_up_fire) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_dn_fire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_next;
      r_up_ready <= (w_count_next != CW'(DEPTH));
      r_dn_valid <= (w_count_next != CW'(0));
    end
  end

`ifdef NODE_ELASTIC_FIFO_STATS_EN
  logic [15:0]   r_stall_cnt;
  logic [CW-1:0] r_hwm;

  assign stall_cnt = r_stall_cnt;
  assign hwm       = r_hwm;

  // Statistics survive flush; hwm follows the registered count, so it trails by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
      r_hwm       <= '0;
    end else begin
      if (r_dn_valid && !dn_ready_in && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      end
      if (r_count > r_hwm) begin
        r_hwm <= r_count;
      end
    end
  end
`endif

endmodule
